// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_pkg
// Desc     : Shared 640x480@60 timing constants, text geometry and sync bundle.
// Revision : 1.0 - initial release
// ============================================================================
package video_pkg;

    localparam int c_ADDR_WIDTH = 16;
    localparam logic [15:0] c_SCREEN_BASE = 16'hF000;
    localparam logic [15:0] c_FONT_BASE   = 16'hE000;

    localparam int c_H_VISIBLE = 640;
    localparam int c_H_FRONT   = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BACK    = 48;
    localparam int c_V_VISIBLE = 480;
    localparam int c_V_FRONT   = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BACK    = 33;

    localparam int c_H_TOTAL      = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;
    localparam int c_V_TOTAL      = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;
    localparam int c_H_SYNC_START = c_H_VISIBLE + c_H_FRONT;
    localparam int c_H_SYNC_END   = c_H_SYNC_START + c_H_SYNC - 1;
    localparam int c_V_SYNC_START = c_V_VISIBLE + c_V_FRONT;
    localparam int c_V_SYNC_END   = c_V_SYNC_START + c_V_SYNC - 1;

    localparam int c_COLS    = 80;
    localparam int c_ROWS    = 30;
    localparam int c_GLYPH_H = 16;

    // Fetch/load takes three dot clocks, so syncs are delayed the same amount.
    localparam int c_PIPE_DEPTH = 3;

    typedef struct packed {
        logic blank;
        logic hsync;
        logic vsync;
    } sync_t;

endpackage
`default_nettype wire

// File: rtl/video_timing.sv
`default_nettype none
// ============================================================================
// Module   : video_timing
// Desc     : Dot/line counters with raw visible, sync, frame and cell position.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing
    import video_pkg::*;
#(
    parameter int H_VISIBLE = c_H_VISIBLE,
    parameter int H_FRONT   = c_H_FRONT,
    parameter int H_SYNC    = c_H_SYNC,
    parameter int H_BACK    = c_H_BACK,
    parameter int V_VISIBLE = c_V_VISIBLE,
    parameter int V_FRONT   = c_V_FRONT,
    parameter int V_SYNC    = c_V_SYNC,
    parameter int V_BACK    = c_V_BACK
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    output logic [6:0] o_col,
    output logic [2:0] o_phase,
    output logic [5:0] o_row,
    output logic [3:0] o_line,
    output logic       o_visible,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_frame
);

    localparam int c_H_TOT  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOT  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_HS_BEG = H_VISIBLE + H_FRONT;
    localparam int c_HS_END = c_HS_BEG + H_SYNC - 1;
    localparam int c_VS_BEG = V_VISIBLE + V_FRONT;
    localparam int c_VS_END = c_VS_BEG + V_SYNC - 1;

    logic [9:0] r_h;
    logic [9:0] r_v;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == 10'(c_H_TOT - 1)) begin
            r_h <= '0;
            r_v <= (r_v == 10'(c_V_TOT - 1)) ? '0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    assign o_col     = r_h[9:3];
    assign o_phase   = r_h[2:0];
    assign o_row     = r_v[9:4];
    assign o_line    = r_v[3:0];
    assign o_visible = (r_h < 10'(H_VISIBLE)) && (r_v < 10'(V_VISIBLE));
    assign o_hsync   = !((r_h >= 10'(c_HS_BEG)) && (r_h <= 10'(c_HS_END)));
    assign o_vsync   = !((r_v >= 10'(c_VS_BEG)) && (r_v <= 10'(c_VS_END)));
    assign o_frame   = (r_h == '0) && (r_v == 10'(V_VISIBLE));

endmodule
`default_nettype wire

// File: rtl/text_video.sv
`default_nettype none
// ============================================================================
// Module   : text_video
// Desc     : 80x30 text-mode scanner producing 640x480 monochrome VGA pixels.
// Config   : TEXT_VIDEO_INVERSE_EN - code bit 7 selects inverse video.
// Revision : 1.0 - initial release
// ============================================================================
module text_video
    import video_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = c_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] SCREEN_BASE = ADDR_WIDTH'(c_SCREEN_BASE),
    parameter logic [ADDR_WIDTH-1:0] FONT_BASE   = ADDR_WIDTH'(c_FONT_BASE),
    parameter int                    H_VISIBLE   = c_H_VISIBLE,
    parameter int                    H_FRONT     = c_H_FRONT,
    parameter int                    H_SYNC      = c_H_SYNC,
    parameter int                    H_BACK      = c_H_BACK,
    parameter int                    V_VISIBLE   = c_V_VISIBLE,
    parameter int                    V_FRONT     = c_V_FRONT,
    parameter int                    V_SYNC      = c_V_SYNC,
    parameter int                    V_BACK      = c_V_BACK
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_cs,
    input  logic [7:0]            i_dat,
    output logic                  o_pixel,
    output logic                  o_blank,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic                  o_frame
);

    logic [6:0] w_col;
    logic [2:0] w_phase;
    logic [5:0] w_row;
    logic [3:0] w_line;
    logic       w_visible;
    logic       w_hsync;
    logic       w_vsync;
    logic       w_frame;

    video_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .o_col     (w_col),
        .o_phase   (w_phase),
        .o_row     (w_row),
        .o_line    (w_line),
        .o_visible (w_visible),
        .o_hsync   (w_hsync),
        .o_vsync   (w_vsync),
        .o_frame   (w_frame)
    );

    // Strobes are gated by reset so the bus stays idle while counters sit at 0.
    logic w_fetch_code;
    logic w_fetch_glyph;
    logic w_load;

    assign w_fetch_code  = i_reset_n && w_visible && (w_phase == 3'd0);
    assign w_fetch_glyph = i_reset_n && w_visible && (w_phase == 3'd1);
    assign w_load        = w_visible && (w_phase == 3'd2);

    logic [ADDR_WIDTH-1:0] w_row_ext;
    logic [ADDR_WIDTH-1:0] w_screen_addr;
    logic [ADDR_WIDTH-1:0] w_font_addr;
    logic [11:0]           w_glyph_idx;
    logic [7:0]            w_glyph;

    assign w_row_ext     = ADDR_WIDTH'(w_row);
    assign w_screen_addr = SCREEN_BASE + (w_row_ext << 6) + (w_row_ext << 4)
                         + ADDR_WIDTH'(w_col);

`ifdef TEXT_VIDEO_INVERSE_EN
    logic r_inverse;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_inverse <= 1'b0;
        end else if (w_fetch_glyph) begin
            r_inverse <= i_dat[7];
        end
    end

    assign w_glyph_idx = {1'b0, i_dat[6:0], w_line};
    assign w_glyph     = i_dat ^ {8{r_inverse}};
`else
    assign w_glyph_idx = {i_dat, w_line};
    assign w_glyph     = i_dat;
`endif

    assign w_font_addr = FONT_BASE + ADDR_WIDTH'(w_glyph_idx);

    always_comb begin
        o_addr = '0;
        if (w_fetch_code) begin
            o_addr = w_screen_addr;
        end else if (w_fetch_glyph) begin
            o_addr = w_font_addr;
        end
    end

    assign o_cs = w_fetch_code | w_fetch_glyph;

    logic [7:0] r_shift;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_shift <= '0;
        end else if (w_load) begin
            r_shift <= w_glyph;
        end else begin
            r_shift <= {r_shift[6:0], 1'b0};
        end
    end

    sync_t                    w_sync_raw;
    sync_t [c_PIPE_DEPTH-1:0] r_sync_pipe;

    assign w_sync_raw = '{blank: !w_visible, hsync: w_hsync, vsync: w_vsync};

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync_pipe <= '1;
        end else begin
            r_sync_pipe <= {r_sync_pipe[c_PIPE_DEPTH-2:0], w_sync_raw};
        end
    end

    assign o_blank = r_sync_pipe[c_PIPE_DEPTH-1].blank;
    assign o_hsync = r_sync_pipe[c_PIPE_DEPTH-1].hsync;
    assign o_vsync = r_sync_pipe[c_PIPE_DEPTH-1].vsync;
    assign o_pixel = r_shift[7] & ~o_blank;
    assign o_frame = w_frame;

endmodule
`default_nettype wire

// File: tb/tb_text_video.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_video
// Desc     : Randomised-screen bench for text_video against a pixel-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_video;

    localparam int c_HT     = 800;
    localparam int c_VT_M   = 525;
    localparam int c_VVIS_M = 480;
    localparam int c_VSS_M  = 490;
    localparam int c_VT_S   = 40;
    localparam int c_VVIS_S = 32;
    localparam int c_VSS_S  = 35;
    localparam int c_CAP    = 40;
`ifdef TEXT_VIDEO_INVERSE_EN
    localparam bit         c_INV   = 1'b1;
    localparam logic [7:0] c_CODE0 = 8'hC1;
`else
    localparam bit         c_INV   = 1'b0;
    localparam logic [7:0] c_CODE0 = 8'h41;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr_m, addr_s;
    logic        cs_m, cs_s;
    logic [7:0]  dat_m, dat_s;
    logic        pix_m, blank_m, hs_m, vs_m, fr_m;
    logic        pix_s, blank_s, hs_s, vs_s, fr_s;
    logic [7:0]  mem [0:65535];
    int          n;
    int          n_checks = 0;
    int          n_fails  = 0;

    always #20 clk = ~clk;

    text_video u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .o_addr(addr_m), .o_cs(cs_m), .i_dat(dat_m),
        .o_pixel(pix_m), .o_blank(blank_m), .o_hsync(hs_m), .o_vsync(vs_m), .o_frame(fr_m)
    );

    text_video #(.V_VISIBLE(c_VVIS_S), .V_FRONT(3), .V_SYNC(2), .V_BACK(3)) u_dut_small (
        .i_clk(clk), .i_reset_n(rst_n), .o_addr(addr_s), .o_cs(cs_s), .i_dat(dat_s),
        .o_pixel(pix_s), .o_blank(blank_s), .o_hsync(hs_s), .o_vsync(vs_s), .o_frame(fr_s)
    );

    // Registered read port: data lands one cycle after a strobed address.
    always @(posedge clk) begin
        dat_m <= cs_m ? mem[addr_m] : 8'h5A;
        dat_s <= cs_s ? mem[addr_s] : 8'h5A;
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] font_index(input logic [7:0] code);
        return c_INV ? {1'b0, code[6:0]} : code;
    endfunction

    function automatic logic [15:0] cell_addr(input int h, input int v);
        return 16'hF000 + 16'((v / 16) * 80 + h / 8);
    endfunction

    function automatic logic [7:0] shown_glyph(input int h, input int v);
        logic [7:0] code;
        logic [7:0] g;
        code = mem[cell_addr(h, v)];
        g = mem[16'hE000 + 16'(int'(font_index(code)) * 16 + v % 16)];
        return (c_INV && code[7]) ? ~g : g;
    endfunction

    // Outputs at dot h of line v describe the raster position three dots earlier.
    function automatic int src_h(input int h);
        return (h >= 3) ? h - 3 : h - 3 + c_HT;
    endfunction

    function automatic int src_v(input int h, input int v, input int vt);
        return (h >= 3) ? v : ((v == 0) ? vt - 1 : v - 1);
    endfunction

    function automatic logic [5:0] exp_vec(input int h, input int v, input int vt,
                                           input int vvis, input int vss);
        int hs, vs;
        logic vis, pix, cs;
        logic [7:0] g;
        hs  = src_h(h);
        vs  = src_v(h, v, vt);
        vis = (hs < 640) && (vs < vvis);
        pix = 1'b0;
        if (vis) begin
            g   = shown_glyph(hs, vs);
            pix = g[7 - hs % 8];
        end
        cs = (h < 640) && (v < vvis) && (h % 8 < 2);
        return {pix, !vis, !(hs >= 656 && hs <= 751), !(vs >= vss && vs <= vss + 1),
                (h == 0) && (v == vvis), cs};
    endfunction

    function automatic logic [15:0] exp_addr(input int h, input int v, input int vvis);
        if (h >= 640 || v >= vvis) return 16'h0000;
        if (h % 8 == 0) return cell_addr(h, v);
        if (h % 8 == 1) return 16'hE000 + 16'(int'(font_index(mem[cell_addr(h, v)])) * 16 + v % 16);
        return 16'h0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({pix_m, blank_m, hs_m, vs_m, fr_m, cs_m} !== 6'b011100) begin
                n_fails++;
                $display("FAIL reset_outputs cycle=%0d got=%b want=011100", i,
                         {pix_m, blank_m, hs_m, vs_m, fr_m, cs_m});
            end
        end
        rst_n = 1'b1;
        #1;
        n = 0;
    endtask

    task automatic test_first_fetch();
        logic [15:0] want;
        n_checks++;
        if (cs_m !== 1'b1 || addr_m !== 16'hF000) begin
            n_fails++;
            $display("FAIL first_code_fetch got cs=%b addr=%h want cs=1 addr=f000", cs_m, addr_m);
        end
        step();
        want = 16'hE000 + 16'(int'(font_index(c_CODE0)) * 16);
        n_checks++;
        if (cs_m !== 1'b1 || addr_m !== want) begin
            n_fails++;
            $display("FAIL first_glyph_fetch got cs=%b addr=%h want cs=1 addr=%h", cs_m, addr_m, want);
        end
        step();
        n_checks++;
        if (cs_m !== 1'b0 || addr_m !== 16'h0000) begin
            n_fails++;
            $display("FAIL idle_phase got cs=%b addr=%h want cs=0 addr=0000", cs_m, addr_m);
        end
    endtask

    task automatic test_first_cell_pixels();
        logic [7:0] g;
        g = c_INV ? 8'h7E : 8'h81;
        for (int b = 7; b >= 0; b--) begin
            step();
            n_checks++;
            if (pix_m !== g[b]) begin
                n_fails++;
                $display("FAIL cell0_pixel h=%0d got=%b want=%b", n, pix_m, g[b]);
            end
        end
    endtask

    task automatic test_hsync();
        int first = -1;
        int cnt = 0;
        while (n < c_HT) begin
            step();
            if (!hs_m) begin
                if (first < 0) first = n;
                cnt++;
            end
        end
        n_checks++;
        if (first != 659 || cnt != 96) begin
            n_fails++;
            $display("FAIL hsync_window got start=%0d len=%0d want start=659 len=96", first, cnt);
        end
    endtask

    task automatic test_scan(input int until_n, input bit count_frames);
        int h, vm, vs;
        int frames = 0, last_fr = -1, vs_low = 0;
        logic [5:0] want;
        while (n < until_n) begin
            if (n == 20000) begin
                mem[16'hF000] = 8'($urandom);
                mem[16'hF001] = 8'($urandom);
            end
            h  = n % c_HT;
            vm = (n / c_HT) % c_VT_M;
            vs = (n / c_HT) % c_VT_S;
            if (n_fails < c_CAP) begin
                want = exp_vec(h, vm, c_VT_M, c_VVIS_M, c_VSS_M);
                n_checks++;
                if ({pix_m, blank_m, hs_m, vs_m, fr_m, cs_m} !== want ||
                    addr_m !== exp_addr(h, vm, c_VVIS_M)) begin
                    n_fails++;
                    $display("FAIL scan_main h=%0d v=%0d got pbhvfc=%b addr=%h want %b addr=%h",
                             h, vm, {pix_m, blank_m, hs_m, vs_m, fr_m, cs_m}, addr_m,
                             want, exp_addr(h, vm, c_VVIS_M));
                end
                want = exp_vec(h, vs, c_VT_S, c_VVIS_S, c_VSS_S);
                n_checks++;
                if ({pix_s, blank_s, hs_s, vs_s, fr_s, cs_s} !== want ||
                    addr_s !== exp_addr(h, vs, c_VVIS_S)) begin
                    n_fails++;
                    $display("FAIL scan_small h=%0d v=%0d got pbhvfc=%b addr=%h want %b addr=%h",
                             h, vs, {pix_s, blank_s, hs_s, vs_s, fr_s, cs_s}, addr_s,
                             want, exp_addr(h, vs, c_VVIS_S));
                end
            end
            if (!vs_s) vs_low++;
            if (fr_s) begin
                frames++;
                if (last_fr >= 0) begin
                    n_checks++;
                    if (n - last_fr != c_HT * c_VT_S) begin
                        n_fails++;
                        $display("FAIL frame_period got=%0d want=%0d", n - last_fr, c_HT * c_VT_S);
                    end
                end
                last_fr = n;
            end
            step();
        end
        if (count_frames) begin
            n_checks++;
            if (frames != 2 || vs_low != 2 * 2 * c_HT) begin
                n_fails++;
                $display("FAIL frame_count got frames=%0d vsync_low=%0d want frames=2 vsync_low=%0d",
                         frames, vs_low, 2 * 2 * c_HT);
            end
        end
    endtask

    task automatic test_mid_reset();
        while (n % c_HT != 333) step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({pix_m, blank_m, hs_m, vs_m, fr_m, cs_m} !== 6'b011100 || addr_m !== 16'h0000 ||
            {pix_s, blank_s, hs_s, vs_s, fr_s, cs_s} !== 6'b011100) begin
            n_fails++;
            $display("FAIL mid_reset got main=%b addr=%h small=%b want 011100 addr=0000",
                     {pix_m, blank_m, hs_m, vs_m, fr_m, cs_m}, addr_m,
                     {pix_s, blank_s, hs_s, vs_s, fr_s, cs_s});
        end
        step();
        rst_n = 1'b1;
        #1;
        n = 0;
        n_checks++;
        if (cs_m !== 1'b1 || addr_m !== 16'hF000) begin
            n_fails++;
            $display("FAIL restart_fetch got cs=%b addr=%h want cs=1 addr=f000", cs_m, addr_m);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        mem[16'hF000] = c_CODE0;
        mem[16'hE000 + 16'h41 * 16] = 8'h81;
        n = 0;
        test_reset();
        test_first_fetch();
        test_first_cell_pixels();
        test_hsync();
        test_scan(70000, 1'b1);
        test_mid_reset();
        test_scan(3000, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
